// File: rtl/rv_mem_imm_unit.sv
// rv_mem_imm_unit: instruction ROM, data RAM with async reset image, and RV32I immediate decoder
module rv_mem_imm_unit #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    imem_addr,
  output logic [WIDTH-1:0] instr,
  input  logic [31:0]      imm_inst,
  output logic [31:0]      imm_out,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic [AW-1:0]    dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  output logic [WIDTH-1:0] dmem_rdata
);
  logic [WIDTH-1:0] ram [DEPTH];
  logic [6:0] op;
  logic [31:0] i;
  assign instr = imem_addr == 0 ? WIDTH'(32'h00002083) :
                 imem_addr == 1 ? WIDTH'(32'h00402103) :
                 imem_addr == 2 ? WIDTH'(32'h002081B3) :
                 imem_addr == 3 ? WIDTH'(32'h00302423) :
                 imem_addr == 4 ? WIDTH'(32'hFE208EE3) : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ram[k] <= '0;
      ram[0] <= WIDTH'(17);
      ram[1] <= WIDTH'(9);
      ram[2] <= WIDTH'(25);
    end else if (dmem_write) ram[dmem_addr] <= dmem_wdata;
  assign dmem_rdata = dmem_read ? ram[dmem_addr] : '0;
  assign i = imm_inst;
  assign op = i[6:0];
  // B and J immediates stay half-scaled; the core appends the implicit zero
  always_comb
    imm_out = (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111) ? {{20{i[31]}}, i[31:20]} :
              op == 7'b0100011 ? {{20{i[31]}}, i[31:25], i[11:7]} :
              op == 7'b1100011 ? {{20{i[31]}}, i[31], i[7], i[30:25], i[11:8]} :
              (op == 7'b0110111 || op == 7'b0010111) ? {i[31:12], 12'h000} :
              op == 7'b1101111 ? {{12{i[31]}}, i[31], i[19:12], i[20], i[30:21]} : '0;
endmodule

// File: tb/tb_rv_mem_imm_unit.sv
// tb_rv_mem_imm_unit: scoreboard bench for ROM, RAM reset/write behaviour and immediate decode
module tb_rv_mem_imm_unit;
  logic clk = 0, clk_en = 0, rst = 1;
  logic [5:0] imem_addr = 0, dmem_addr = 0;
  logic [31:0] instr, imm_inst = 0, imm_out, dmem_wdata = 0, dmem_rdata;
  logic dmem_read = 0, dmem_write = 0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] sb [$];
  logic [31:0] shadow [64];

  rv_mem_imm_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .instr(instr),
    .imm_inst(imm_inst), .imm_out(imm_out), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: scoreboard empty, got %08h expected an entry", tag, got);
    end else begin
      e = sb.pop_front();
      check(tag, got, e);
    end
  endtask

  task automatic rom(input logic [5:0] a, input logic [31:0] e);
    imem_addr = a; sb.push_back(e); #1; pop_check($sformatf("rom[%0d]", a), instr);
  endtask

  task automatic imm(input logic [31:0] ins, input logic [31:0] e);
    imm_inst = ins; sb.push_back(e); #1; pop_check($sformatf("imm %08h", ins), imm_out);
  endtask

  task automatic rd(input logic [5:0] a, input logic re, input string tag, input logic [31:0] e);
    dmem_addr = a; dmem_read = re; sb.push_back(e); #1; pop_check(tag, dmem_rdata);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    dmem_write = 1; dmem_addr = a; dmem_wdata = d;
    @(posedge clk); #1;
    dmem_write = 0;
  endtask

  task automatic pulse_rst;
    #2 rst = 0; #2 rst = 1; #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pulse_rst();
    rom(0, 32'h00002083); rom(1, 32'h00402103); rom(2, 32'h002081B3);
    rom(3, 32'h00302423); rom(4, 32'hFE208EE3); rom(5, 32'h0); rom(63, 32'h0);
    rd(0, 1, "rst w0", 17); rd(1, 1, "rst w1", 9); rd(2, 1, "rst w2", 25);
    rd(3, 1, "rst w3", 0); rd(0, 0, "rd off", 0);
    rst = 0; #1; rd(1, 1, "in rst w1", 9); rom(1, 32'h00402103); rst = 1; #1;
    imm(32'h00402103, 32'h4); imm(32'h00302423, 32'h8); imm(32'hFFF00093, 32'hFFFFFFFF);
    imm(32'h80002083, 32'hFFFFF800); imm(32'h00C000E7, 32'hC); imm(32'h7FF00013, 32'h7FF);
    imm(32'hFE112E23, 32'hFFFFFFFC); imm(32'hFE208EE3, 32'hFFFFFFFE);
    imm(32'h123450B7, 32'h12345000); imm(32'hFFFFF017, 32'hFFFFF000);
    imm(32'h0080006F, 32'h4); imm(32'hFFDFF0EF, 32'hFFFFFFFE); imm(32'h002081B3, 32'h0);
    clk_en = 1;
    @(negedge clk);
    dmem_write = 1; dmem_wdata = 32'hDEADBEEF;
    rd(2, 1, "rdw old", 25);
    @(posedge clk); #1;
    rd(2, 1, "rdw new", 32'hDEADBEEF);
    @(negedge clk);
    dmem_wdata = 32'h12345678; #1;
    rst = 0; #1;
    rd(2, 1, "rst midwr", 25);
    @(posedge clk); #1;
    rd(2, 1, "no wr in rst", 25);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    rd(2, 1, "wr after rel", 32'h12345678);
    dmem_write = 0;
    @(negedge clk); dmem_read = 0; dmem_addr = 1; dmem_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rd(1, 0, "idle rdata", 0); rd(1, 1, "idle held", 9);
    wr(63, 32'hA5A5F00D);
    rd(63, 1, "w63", 32'hA5A5F00D); rd(0, 1, "w0 kept", 17);
    pulse_rst();
    for (int k = 0; k < 64; k++) shadow[k] = 0;
    shadow[0] = 17; shadow[1] = 9; shadow[2] = 25;
    for (int k = 0; k < 40; k++) begin
      logic [5:0] a;
      logic [31:0] d;
      a = 6'($urandom_range(0, 63)); d = $urandom;
      shadow[a] = d;
      wr(a, d);
    end
    for (int k = 0; k < 64; k++) rd(6'(k), 1, $sformatf("rand w%0d", k), shadow[k]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
